// File: rtl/seven_seg_pkg.sv
`default_nettype none
// Segment patterns for a 7-segment digit, ordered {a,b,c,d,e,f,g} with 1 = lit,
// plus the font selector encodings used by bcd_to_7seg.
package seven_seg_pkg;

  localparam int FONT_CODE_B = 0;
  localparam int FONT_HEX    = 1;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;

  // Code-B glyphs for codes A-F.
  localparam logic [6:0] SEG_DASH  = 7'h01;
  localparam logic [6:0] SEG_E     = 7'h4F;
  localparam logic [6:0] SEG_H     = 7'h37;
  localparam logic [6:0] SEG_L     = 7'h0E;
  localparam logic [6:0] SEG_P     = 7'h67;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h1F;
  localparam logic [6:0] SEG_HEX_C = 7'h4E;
  localparam logic [6:0] SEG_HEX_D = 7'h3D;
  localparam logic [6:0] SEG_HEX_E = 7'h4F;
  localparam logic [6:0] SEG_HEX_F = 7'h47;

endpackage
`default_nettype wire

// File: rtl/bcd_to_7seg.sv
`default_nettype none
// Digit-code to 7-segment decoder with selectable font, optional output
// register and optional common-anode inversion. Revision 1.0.
module bcd_to_7seg
  import seven_seg_pkg::*;
#(
  parameter int FONT       = FONT_CODE_B,
  parameter int REGISTERED = 0,
  parameter int INVERT     = 0
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [3:0] i_bcd,
  output logic [6:0] o_led
);

  // No default arm: an unknown code must propagate X rather than a pattern.
  function automatic logic [6:0] font_lookup(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = (FONT == FONT_HEX) ? SEG_HEX_A : SEG_DASH;
      4'hB: seg = (FONT == FONT_HEX) ? SEG_HEX_B : SEG_E;
      4'hC: seg = (FONT == FONT_HEX) ? SEG_HEX_C : SEG_H;
      4'hD: seg = (FONT == FONT_HEX) ? SEG_HEX_D : SEG_L;
      4'hE: seg = (FONT == FONT_HEX) ? SEG_HEX_E : SEG_P;
      4'hF: seg = (FONT == FONT_HEX) ? SEG_HEX_F : SEG_BLANK;
    endcase
    return seg;
  endfunction

  logic [6:0] seg_core;

  if (REGISTERED != 0) begin : g_reg
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) seg_core <= SEG_BLANK;
      else            seg_core <= font_lookup(i_bcd);
    end
  end else begin : g_comb
    // Clock and reset are intentionally ignored in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, i_clk, i_reset_n};
    always_comb seg_core = font_lookup(i_bcd);
  end

  assign o_led = (INVERT != 0) ? ~seg_core : seg_core;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_7seg.sv
`default_nettype none
// Bench for bcd_to_7seg: font tables, inversion, registered timing and reset,
// and digit-byte decode against a MAX7219 Code-B model.
module tb_bcd_to_7seg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] bcd_c = 4'h0;
  logic [3:0] bcd_r = 4'h0;
  logic [6:0] led_b, led_h, led_i, led_r, led_ri;

  always #5 clk = ~clk;

  bcd_to_7seg #(.FONT(0), .REGISTERED(0), .INVERT(0)) u_comb_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_bcd(bcd_c), .o_led(led_b));
  bcd_to_7seg #(.FONT(1), .REGISTERED(0), .INVERT(0)) u_comb_h (
    .i_clk(1'b0), .i_reset_n(1'b0), .i_bcd(bcd_c), .o_led(led_h));
  bcd_to_7seg #(.FONT(0), .REGISTERED(0), .INVERT(1)) u_comb_i (
    .i_clk(1'b1), .i_reset_n(1'b1), .i_bcd(bcd_c), .o_led(led_i));
  bcd_to_7seg #(.FONT(0), .REGISTERED(1), .INVERT(0)) u_reg (
    .i_clk(clk), .i_reset_n(rst_n), .i_bcd(bcd_r), .o_led(led_r));
  bcd_to_7seg #(.FONT(0), .REGISTERED(1), .INVERT(1)) u_reg_i (
    .i_clk(clk), .i_reset_n(rst_n), .i_bcd(bcd_r), .o_led(led_ri));

  typedef struct {
    logic [3:0] bcd;
    logic [6:0] exp_b;
    logic [6:0] exp_h;
  } vec_t;

  vec_t       tbl[16];
  int         total = 0;
  int         bad = 0;
  logic [6:0] exp_q[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // MAX7219 decode-mode digit register: D7 = DP, D3..D0 = Code-B character.
  function automatic logic [7:0] max7219_decode(input logic [7:0] digit);
    logic [6:0] s;
    case (digit[3:0])
      4'h0: s = 7'b1111110;  4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;  4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;  4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;  4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;  4'h9: s = 7'b1111011;
      4'hA: s = 7'b0000001;  4'hB: s = 7'b1001111;
      4'hC: s = 7'b0110111;  4'hD: s = 7'b0001110;
      4'hE: s = 7'b1100111;  default: s = 7'b0000000;
    endcase
    return {digit[7], s};
  endfunction

  task automatic pop_check(input string name);
    logic [6:0] e;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: got empty scoreboard want one entry", name);
    end else begin
      e = exp_q.pop_front();
      check(name, {1'b0, led_r}, {1'b0, e});
      check({name, "_inv"}, {1'b0, led_ri}, {1'b0, ~e});
    end
  endtask

  initial begin
    tbl[0]  = '{4'h0, 7'h7E, 7'h7E};  tbl[1]  = '{4'h1, 7'h30, 7'h30};
    tbl[2]  = '{4'h2, 7'h6D, 7'h6D};  tbl[3]  = '{4'h3, 7'h79, 7'h79};
    tbl[4]  = '{4'h4, 7'h33, 7'h33};  tbl[5]  = '{4'h5, 7'h5B, 7'h5B};
    tbl[6]  = '{4'h6, 7'h5F, 7'h5F};  tbl[7]  = '{4'h7, 7'h70, 7'h70};
    tbl[8]  = '{4'h8, 7'h7F, 7'h7F};  tbl[9]  = '{4'h9, 7'h7B, 7'h7B};
    tbl[10] = '{4'hA, 7'h01, 7'h77};  tbl[11] = '{4'hB, 7'h4F, 7'h1F};
    tbl[12] = '{4'hC, 7'h37, 7'h4E};  tbl[13] = '{4'hD, 7'h0E, 7'h3D};
    tbl[14] = '{4'hE, 7'h67, 7'h4F};  tbl[15] = '{4'hF, 7'h00, 7'h47};

    // Reset state of the registered builds, clock running.
    #1;
    check("reset_blank", {1'b0, led_r}, 8'h00);
    check("reset_blank_inv", {1'b0, led_ri}, 8'h7F);

    // Combinational sweep, first with reset asserted, then released.
    for (int pass = 0; pass < 2; pass++) begin
      rst_n = (pass == 1);
      for (int i = 0; i < 16; i++) begin
        bcd_c = tbl[i].bcd;
        #1;
        check($sformatf("codeb_%0h_p%0d", i, pass), {1'b0, led_b}, {1'b0, tbl[i].exp_b});
        check($sformatf("hex_%0h_p%0d", i, pass), {1'b0, led_h}, {1'b0, tbl[i].exp_h});
        check($sformatf("inv_%0h_p%0d", i, pass), {1'b0, led_i}, {1'b0, ~tbl[i].exp_b});
      end
    end

    // Digit byte with DP as bit 7 against the MAX7219 Code-B decoder.
    for (int i = 0; i < 16; i++) begin
      logic dp;
      dp = i[0] ^ i[2];
      bcd_c = tbl[i].bcd;
      #1;
      check($sformatf("max7219_%0h", i), {dp, led_b}, max7219_decode({dp, 3'b000, tbl[i].bcd}));
    end

    // Registered: reset release, first edge loads, mid-cycle changes held off.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bcd_r = 4'h3;
    exp_q.push_back(7'h79);
    #1;
    check("pre_edge_hold", {1'b0, led_r}, 8'h00);
    @(posedge clk); #1;
    pop_check("first_edge_load");
    @(negedge clk);
    bcd_r = 4'h9;
    exp_q.push_back(7'h7B);
    #1;
    check("mid_cycle_hold", {1'b0, led_r}, 8'h79);
    @(posedge clk); #1;
    pop_check("next_edge_load");

    // Asynchronous reset between edges with 7B showing.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset", {1'b0, led_r}, 8'h00);
    check("async_reset_inv", {1'b0, led_ri}, 8'h7F);
    @(posedge clk); #1;
    check("reset_held_over_edge", {1'b0, led_r}, 8'h00);

    // Registered sweep through the scoreboard.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      int k;
      k = (i * 7) % 16;
      bcd_r = tbl[k].bcd;
      exp_q.push_back(tbl[k].exp_b);
      @(posedge clk); #1;
      pop_check($sformatf("reg_%0h", k));
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
